// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide issue/writeback controller.
// Command, unit-op and state encodings plus the result width.
package muldiv_pkg;

    localparam int RES_W = 32;

    localparam logic [2:0] CMD_NONE = 3'd0;
    localparam logic [2:0] CMD_MULT = 3'd1;
    localparam logic [2:0] CMD_DIV  = 3'd2;
    localparam logic [2:0] CMD_MTHI = 3'd3;
    localparam logic [2:0] CMD_MTLO = 3'd4;
    localparam logic [2:0] CMD_MFHI = 3'd5;
    localparam logic [2:0] CMD_MFLO = 3'd6;
    localparam logic [2:0] CMD_RSVD = 3'd7;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_MUL  = 2'd1;
    localparam logic [1:0] OP_DIV  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_hilo_ctrl.sv
// Issues MULT/DIV to the multiply/divide unit, captures its result into HI/LO,
// serves MTHI/MTLO/MFHI/MFLO and stalls the pipeline while an operation is in flight.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | accepts commands; HI/LO reads and writes happen here
// S_LAUNCH | one-cycle md_start pulse with latched op/operands
// S_WAIT   | polls md_busy; captures result or aborts on timeout
module muldiv_hilo_ctrl
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [2:0]       in_cmd,
    input  logic             in_sign,
    input  logic [RES_W-1:0] in_src0,
    input  logic [RES_W-1:0] in_src1,
    output logic             out_stall,
    output logic [RES_W-1:0] out_rdata,
    output logic             out_err,
    output logic             md_start,
    output logic [1:0]       md_op,
    output logic             md_sign,
    output logic [RES_W-1:0] md_src0,
    output logic [RES_W-1:0] md_src1,
    input  logic             md_busy,
    input  logic [RES_W-1:0] md_res0,
    input  logic [RES_W-1:0] md_res1
);

    localparam int              CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [RES_W-1:0]  hi_q, lo_q, src0_q, src1_q;
    logic [1:0]        op_q;
    logic              sign_q;
    logic [CW-1:0]     cnt_q;
    logic              err_q;

    logic idle, cmd_live, accept_md, wr_hi, wr_lo, capture, abort;

    always_comb begin
        idle      = (state_q == S_IDLE);
        cmd_live  = in_valid && (in_cmd != CMD_NONE) && (in_cmd != CMD_RSVD);
        out_stall = cmd_live && !idle;
        accept_md = in_valid && idle && ((in_cmd == CMD_MULT) || (in_cmd == CMD_DIV));
        wr_hi     = in_valid && idle && (in_cmd == CMD_MTHI);
        wr_lo     = in_valid && idle && (in_cmd == CMD_MTLO);
        capture   = (state_q == S_WAIT) && !md_busy;
        abort     = (state_q == S_WAIT) && md_busy && (cnt_q == CNT_LAST);

        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept_md) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT:   if (capture || abort) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        md_start = (state_q == S_LAUNCH);
        md_op    = md_start ? op_q : OP_NONE;
        md_sign  = sign_q;
        md_src0  = src0_q;
        md_src1  = src1_q;
        out_err  = err_q;

        out_rdata = '0;
        if (in_valid && idle) begin
            if (in_cmd == CMD_MFHI) out_rdata = hi_q;
            else if (in_cmd == CMD_MFLO) out_rdata = lo_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            src0_q <= '0;
            src1_q <= '0;
            sign_q <= 1'b0;
            op_q   <= OP_NONE;
        end else if (accept_md) begin
            src0_q <= in_src0;
            src1_q <= in_src1;
            sign_q <= in_sign;
            op_q   <= (in_cmd == CMD_MULT) ? OP_MUL : OP_DIV;
        end
    end

    // Counts busy WAIT cycles; the last permitted one aborts instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (state_q == S_LAUNCH) begin
            cnt_q <= '0;
        end else if ((state_q == S_WAIT) && md_busy && !abort) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi_q  <= '0;
            lo_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (capture) begin
                hi_q <= md_res1;
                lo_q <= md_res0;
            end else begin
                if (wr_hi) hi_q <= in_src0;
                if (wr_lo) lo_q <= in_src0;
            end
            if (abort) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl with a small behavioural mul/div unit.
// Expected values are hand-computed constants.
module tb_muldiv_hilo_ctrl;

    logic        clock, reset;
    logic        in_valid, in_sign;
    logic [2:0]  in_cmd;
    logic [31:0] in_src0, in_src1;
    logic        out_stall, out_err, md_start, md_sign, md_busy;
    logic [31:0] out_rdata, md_src0, md_src1, md_res0, md_res1;
    logic [1:0]  md_op;

    int total = 0;
    int bad   = 0;
    int starts = 0;
    int busy_cnt;
    int busy_len = 0;
    int n;

    muldiv_hilo_ctrl #(.TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_cmd(in_cmd), .in_sign(in_sign),
        .in_src0(in_src0), .in_src1(in_src1),
        .out_stall(out_stall), .out_rdata(out_rdata), .out_err(out_err),
        .md_start(md_start), .md_op(md_op), .md_sign(md_sign),
        .md_src0(md_src0), .md_src1(md_src1),
        .md_busy(md_busy), .md_res0(md_res0), .md_res1(md_res1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural unit: busy for busy_len cycles after each start pulse.
    assign md_busy = (busy_cnt != 0);
    always @(posedge clock or negedge reset) begin
        logic [63:0] prod;
        if (!reset) begin
            busy_cnt <= 0;
            md_res0  <= '0;
            md_res1  <= '0;
        end else if (md_start) begin
            busy_cnt <= busy_len;
            if (md_op == 2'd1) begin
                if (md_sign) prod = {{32{md_src0[31]}}, md_src0} * {{32{md_src1[31]}}, md_src1};
                else         prod = {32'd0, md_src0} * {32'd0, md_src1};
                md_res0 <= prod[31:0];
                md_res1 <= prod[63:32];
            end else if (md_src1 == 32'd0) begin
                md_res0 <= 32'hFFFF_FFFF;
                md_res1 <= md_src0;
            end else begin
                md_res0 <= md_src0 / md_src1;
                md_res1 <= md_src0 % md_src1;
            end
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    always @(posedge clock) if (md_start) starts++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_cmd(input logic v, input logic [2:0] c, input logic s,
                           input logic [31:0] a, input logic [31:0] b);
        in_valid = v; in_cmd = c; in_sign = s; in_src0 = a; in_src1 = b;
    endtask

    task automatic samp();
        @(negedge clock);
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    // Counts stalled cycles; returns at a negedge with out_stall low.
    task automatic wait_unstall(output int cnt);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            samp();
            if (!out_stall) return;
            cnt++;
            adv();
        end
        chk("stall_bound", 64'(out_stall), 64'd0);
    endtask

    initial begin
        reset = 1'b0;
        set_cmd(1'b1, 3'd5, 1'b0, 32'd0, 32'd0);
        repeat (2) adv();
        samp();
        chk("rst_stall", 64'(out_stall), 64'd0);
        chk("rst_rdata", 64'(out_rdata), 64'd0);
        chk("rst_start", 64'(md_start), 64'd0);
        chk("rst_op",    64'(md_op),    64'd0);
        chk("rst_err",   64'(out_err),  64'd0);
        chk("rst_src0",  64'(md_src0),  64'd0);
        adv();
        reset = 1'b1;
        adv();

        // signed MULT -3 * 5
        set_cmd(1'b1, 3'd1, 1'b1, 32'hFFFF_FFFD, 32'd5);
        busy_len = 4;
        samp();
        chk("s1_accept_stall", 64'(out_stall), 64'd0);
        adv();
        set_cmd(1'b0, 3'd0, 1'b0, 32'd0, 32'd0);
        samp();
        chk("s1_start", 64'(md_start), 64'd1);
        chk("s1_op",    64'(md_op),    64'd1);
        chk("s1_src0",  64'(md_src0),  64'hFFFF_FFFD);
        chk("s1_src1",  64'(md_src1),  64'd5);
        chk("s1_sign",  64'(md_sign),  64'd1);
        adv();
        chk("s1_op_idle", 64'(md_op), 64'd0);
        set_cmd(1'b1, 3'd6, 1'b0, 32'd0, 32'd0);
        wait_unstall(n);
        chk("s1_mflo", 64'(out_rdata), 64'hFFFF_FFF1);
        adv();
        set_cmd(1'b1, 3'd5, 1'b0, 32'd0, 32'd0);
        samp();
        chk("s1_mfhi", 64'(out_rdata), 64'hFFFF_FFFF);
        chk("s1_starts", 64'(starts), 64'd1);
        adv();

        // unsigned DIV 100 / 7 with a held MFHI
        set_cmd(1'b1, 3'd2, 1'b0, 32'd100, 32'd7);
        busy_len = 2;
        samp();
        chk("s2_accept_stall", 64'(out_stall), 64'd0);
        adv();
        set_cmd(1'b1, 3'd5, 1'b0, 32'd0, 32'd0);
        samp();
        chk("s2_launch_stall", 64'(out_stall), 64'd1);
        chk("s2_stall_rdata",  64'(out_rdata), 64'd0);
        chk("s2_op",           64'(md_op),     64'd2);
        adv();
        wait_unstall(n);
        chk("s2_wait_stalls", 64'(n), 64'd3);
        chk("s2_mfhi", 64'(out_rdata), 64'd2);
        adv();
        set_cmd(1'b1, 3'd6, 1'b0, 32'd0, 32'd0);
        samp();
        chk("s2_mflo", 64'(out_rdata), 64'd14);
        adv();

        // MTHI then MFHI, then MTLO then MFLO
        set_cmd(1'b1, 3'd3, 1'b0, 32'h1234_5678, 32'd0);
        samp();
        chk("s3_mthi_stall", 64'(out_stall), 64'd0);
        adv();
        set_cmd(1'b1, 3'd5, 1'b0, 32'd0, 32'd0);
        samp();
        chk("s3_mfhi", 64'(out_rdata), 64'h1234_5678);
        chk("s3_mfhi_stall", 64'(out_stall), 64'd0);
        adv();
        set_cmd(1'b1, 3'd4, 1'b0, 32'hCAFE_F00D, 32'd0);
        adv();
        set_cmd(1'b1, 3'd6, 1'b0, 32'd0, 32'd0);
        samp();
        chk("s3_mflo", 64'(out_rdata), 64'hCAFE_F00D);
        chk("s3_starts", 64'(starts), 64'd2);
        adv();

        // timeout: unit stays busy
        set_cmd(1'b1, 3'd1, 1'b0, 32'd2, 32'd3);
        busy_len = 1000;
        adv();
        set_cmd(1'b1, 3'd5, 1'b0, 32'd0, 32'd0);
        samp();
        chk("s4_launch_stall", 64'(out_stall), 64'd1);
        chk("s4_err_before",   64'(out_err),   64'd0);
        adv();
        wait_unstall(n);
        chk("s4_wait_cycles", 64'(n), 64'd16);
        chk("s4_err", 64'(out_err), 64'd1);
        chk("s4_hi_kept", 64'(out_rdata), 64'h1234_5678);
        adv();
        set_cmd(1'b1, 3'd6, 1'b0, 32'd0, 32'd0);
        samp();
        chk("s4_lo_kept", 64'(out_rdata), 64'hCAFE_F00D);
        adv();
        set_cmd(1'b0, 3'd0, 1'b0, 32'd0, 32'd0);
        repeat (5) adv();
        samp();
        chk("s4_err_sticky", 64'(out_err), 64'd1);
        adv();

        // reset two cycles into WAIT
        set_cmd(1'b1, 3'd1, 1'b0, 32'd9, 32'd9);
        busy_len = 10;
        adv();
        set_cmd(1'b1, 3'd5, 1'b0, 32'd0, 32'd0);
        adv();
        adv();
        samp();
        chk("s5_wait_stall", 64'(out_stall), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("s5_rst_stall", 64'(out_stall), 64'd0);
        chk("s5_rst_hi",    64'(out_rdata), 64'd0);
        chk("s5_rst_start", 64'(md_start),  64'd0);
        chk("s5_rst_err",   64'(out_err),   64'd0);
        set_cmd(1'b1, 3'd6, 1'b0, 32'd0, 32'd0);
        #1;
        chk("s5_rst_lo", 64'(out_rdata), 64'd0);
        adv();
        reset = 1'b1;
        set_cmd(1'b1, 3'd1, 1'b0, 32'd6, 32'd7);
        busy_len = 1;
        samp();
        chk("s5_accept_stall", 64'(out_stall), 64'd0);
        adv();
        set_cmd(1'b1, 3'd6, 1'b0, 32'd0, 32'd0);
        samp();
        chk("s5_start", 64'(md_start), 64'd1);
        adv();
        wait_unstall(n);
        chk("s5_mflo", 64'(out_rdata), 64'd42);
        adv();

        // NONE/reserved during an op never stall; a DIV queued behind MULT overwrites it
        set_cmd(1'b1, 3'd1, 1'b0, 32'd3, 32'd4);
        busy_len = 3;
        adv();
        set_cmd(1'b1, 3'd0, 1'b0, 32'd0, 32'd0);
        samp();
        chk("s6_none_stall", 64'(out_stall), 64'd0);
        adv();
        set_cmd(1'b1, 3'd7, 1'b0, 32'd0, 32'd0);
        samp();
        chk("s6_rsvd_stall", 64'(out_stall), 64'd0);
        adv();
        set_cmd(1'b1, 3'd2, 1'b0, 32'd50, 32'd8);
        wait_unstall(n);
        chk("s6_div_stalls", 64'(n), 64'd3);
        chk("s6_accept_start", 64'(md_start), 64'd0);
        adv();
        set_cmd(1'b1, 3'd6, 1'b0, 32'd0, 32'd0);
        samp();
        chk("s6_div_start", 64'(md_start), 64'd1);
        chk("s6_div_op",    64'(md_op),    64'd2);
        chk("s6_div_src0",  64'(md_src0),  64'd50);
        adv();
        wait_unstall(n);
        chk("s6_mflo", 64'(out_rdata), 64'd6);
        adv();
        set_cmd(1'b1, 3'd5, 1'b0, 32'd0, 32'd0);
        samp();
        chk("s6_mfhi", 64'(out_rdata), 64'd2);
        adv();
        set_cmd(1'b0, 3'd0, 1'b0, 32'd0, 32'd0);
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/muldiv_hilo_ctrl.md
# muldiv_hilo_ctrl

Issue/writeback controller sitting between the execute stage and the multiply/divide unit. It accepts MULT/DIV/MTHI/MTLO/MFHI/MFLO commands, launches the unit with registered operands, and waits on its busy flag. It then captures the 64-bit result into the architectural HI/LO registers and stalls the pipeline while an operation is in flight.

## Interface
- TIMEOUT, 64: maximum cycles spent in WAIT before abort; range 8..1023.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- in_valid  in  1  execute-stage command valid.
- in_cmd  in  3  0 NONE, 1 MULT, 2 DIV, 3 MTHI, 4 MTLO, 5 MFHI, 6 MFLO, 7 reserved (treated as NONE).
- in_sign  in  1  signed MULT/DIV.
- in_src0, in_src1  in  32  operands; in_src0 is also the MTHI/MTLO data.
- out_stall  out  1  pipeline must hold the current command.
- out_rdata  out  32  HI for MFHI, LO for MFLO, else 0.
- out_err  out  1  sticky timeout flag; cleared only by reset.
- md_start  out  1  one-cycle launch pulse to the unit.
- md_op  out  2  1 mult, 2 div; 0 when md_start is low.
- md_sign  out  1  registered sign.
- md_src0, md_src1  out  32  registered operands.
- md_busy  in  1  unit busy.
- md_res0, md_res1  in  32  unit result: low word/quotient, high word/remainder.

## Operation
- States:
  - IDLE: accepts commands.
  - LAUNCH: md_start=1, md_op valid for exactly one cycle.
  - WAIT: polls md_busy.
- Reset values: state IDLE; HI=LO=0; operand/op/sign registers 0; timeout counter 0; md_start=0, md_op=0, out_stall=0, out_rdata=0, out_err=0.
- IDLE with in_valid:
  - MULT/DIV: latch src0, src1, sign and op (MULT→1, DIV→2); go to LAUNCH. out_stall=0 that cycle (command consumed).
  - MTHI/MTLO: HI or LO ← in_src0 at the edge. State stays IDLE.
  - MFHI/MFLO: out_rdata = current HI/LO combinationally, no stall.
- LAUNCH: md_busy is ignored because the unit's busy is registered. Clear the counter and go to WAIT.
- WAIT:
  - md_busy=0: HI←md_res1, LO←md_res0; go to IDLE.
  - md_busy=1: increment the counter. When the counter reaches TIMEOUT-1 while still busy: set out_err, go to IDLE, leave HI/LO unchanged.
- out_stall = in_valid & (in_cmd ∈ 1..6) & (state ≠ IDLE). NONE/reserved never stall.
- While out_stall=1:
  - no register writes from the stalled command;
  - out_rdata=0.
- Division by zero is not special-cased. HI/LO take whatever the unit returns.
- Reset asserted mid-operation: immediate return to the reset state, with no capture and no start pulse.

## Timing
- MULT/DIV accepted at edge N. md_start is high in cycle N+1. The earliest capture is at the end of cycle N+2 (when md_busy is already 0 in N+2). The first unstalled command is in cycle N+3.
- A MFHI/MFLO stalled behind an operation is released in the first IDLE cycle. It reads the newly captured value.
- MTHI/MTLO followed immediately by MFHI/MFLO: the read sees the written value (one-edge write latency).
- Back-to-back MULT→DIV: the DIV stalls until IDLE, then is accepted. The second result overwrites the first.
- Minimum occupancy per MULT/DIV is 3 cycles. The maximum is TIMEOUT+2.

## Structure
- Shared package muldiv_pkg:
  - command encodings (CMD_NONE..CMD_MFLO);
  - unit op encodings (OP_MUL=1, OP_DIV=2);
  - state enum (S_IDLE, S_LAUNCH, S_WAIT);
  - result width constant 32.
- Single flat module. The timeout counter is $clog2(TIMEOUT) bits wide, internal. No sub-module is warranted.

## Test plan
- Signed MULT src0=0xFFFFFFFD, src1=5, model busy for 4 cycles → one md_start pulse with md_op=1; then HI=0xFFFFFFFF, LO=0xFFFFFFF1; MFLO returns 0xFFFFFFF1.
- Unsigned DIV 100/7, model returns res0=14, res1=2 → LO=14, HI=2; out_stall high from cycle N+1 to capture for a held MFHI, which then reads 2.
- MTHI 0x12345678 then MFHI next cycle → out_rdata=0x12345678, no stall at any point, md_start never asserted.
- Model holds md_busy=1 forever with TIMEOUT=16 → out_err rises after 16 WAIT cycles, state returns to IDLE, HI/LO keep prior values, out_err remains 1.
- Reset driven low two cycles into WAIT → asynchronously: out_stall=0, HI=LO=0, md_start=0. A MULT issued after reset release launches normally.
- MULT in IDLE with a NONE/reserved command during WAIT → out_stall stays 0 for those cycles. A DIV issued during WAIT stalls, then launches exactly one cycle after the MULT capture.
